// File: rtl/pio_led_ctrl.sv
// LED pattern controller driven by a 4-bit PIO command word.
// Modes: OFF, BLINK, CHASE (rotate), PWM; rate/duty in cmd[1:0].
module pio_led_ctrl #(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned STEP_TICKS = 250
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] cmd,
    output logic [3:0] led_out,
    output logic       active,
    output logic       cmd_evt
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_BLINK = 2'b01,
        MODE_CHASE = 2'b10,
        MODE_PWM   = 2'b11
    } mode_e;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [11:0] STEP_BASE = 12'(STEP_TICKS);

    logic [3:0]  sync1_q, sync1_d;
    logic [3:0]  cmd_s_q, cmd_s_d;
    logic [3:0]  cmd_q, cmd_d;
    logic        cmd_evt_q, cmd_evt_d;
    logic [15:0] presc_q, presc_d;
    logic [11:0] step_cnt_q, step_cnt_d;
    logic [1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [3:0]  pattern_q, pattern_d;
    logic [3:0]  led_out_q, led_out_d;
    logic        active_q, active_d;

    mode_e       mode;
    logic        tick;
    logic        step;
    logic [11:0] step_last;

    always_comb begin
        sync1_d   = cmd;
        cmd_s_d   = sync1_q;
        cmd_evt_d = (cmd_s_q != cmd_q);
        cmd_d     = cmd_evt_d ? cmd_s_q : cmd_q;

        tick    = (presc_q == TICK_LAST);
        presc_d = tick ? '0 : presc_q + 16'd1;

        mode      = mode_e'(cmd_q[3:2]);
        step_last = (STEP_BASE << cmd_q[1:0]) - 12'd1;
        step      = tick && (step_cnt_q == step_last);
    end

    // A registered change event restarts everything and swallows any coincident tick/step.
    always_comb begin
        step_cnt_d = step_cnt_q;
        pwm_cnt_d  = pwm_cnt_q;
        pattern_d  = pattern_q;
        if (cmd_evt_q) begin
            step_cnt_d = '0;
            pwm_cnt_d  = '0;
            unique case (mode)
                MODE_BLINK: pattern_d = 4'hF;
                MODE_CHASE: pattern_d = 4'b0001;
                default:    pattern_d = '0;
            endcase
        end else if (tick) begin
            step_cnt_d = step ? '0 : step_cnt_q + 12'd1;
            pwm_cnt_d  = pwm_cnt_q + 2'd1;
            if (step) begin
                unique case (mode)
                    MODE_BLINK: pattern_d = ~pattern_q;
                    MODE_CHASE: pattern_d = {pattern_q[2:0], pattern_q[3]};
                    default:    pattern_d = pattern_q;
                endcase
            end
        end
    end

    always_comb begin
        led_out_d = '0;
        unique case (mode)
            MODE_OFF:   led_out_d = '0;
            MODE_BLINK,
            MODE_CHASE: led_out_d = pattern_d;
            MODE_PWM:   led_out_d = (pwm_cnt_d <= cmd_q[1:0]) ? 4'hF : 4'h0;
            default:    led_out_d = '0;
        endcase
        active_d = (mode != MODE_OFF);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            cmd_s_q    <= '0;
            cmd_q      <= '0;
            cmd_evt_q  <= '0;
            presc_q    <= '0;
            step_cnt_q <= '0;
            pwm_cnt_q  <= '0;
            pattern_q  <= '0;
            led_out_q  <= '0;
            active_q   <= '0;
        end else begin
            sync1_q    <= sync1_d;
            cmd_s_q    <= cmd_s_d;
            cmd_q      <= cmd_d;
            cmd_evt_q  <= cmd_evt_d;
            presc_q    <= presc_d;
            step_cnt_q <= step_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            pattern_q  <= pattern_d;
            led_out_q  <= led_out_d;
            active_q   <= active_d;
        end
    end

    assign led_out = led_out_q;
    assign active  = active_q;
    assign cmd_evt = cmd_evt_q;

endmodule

// File: doc/pio_led_ctrl.md
PIO_LED_CTRL -- requirements
Module: pio_led_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000: clk cycles per tick; legal range 1..65535.
REQ-002 Parameter STEP_TICKS, default 250: base step period in ticks; legal range 1..511.
REQ-003 clk  input  1  system clock; all state is updated on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd  input  4  command word driven by the upstream 4-bit output PIO port: cmd[3:2] is the mode, cmd[1:0] is rate/duty.
REQ-006 led_out  output  4  registered LED drive.
REQ-007 active  output  1  registered; 1 when the latched mode is not OFF.
REQ-008 cmd_evt  output  1  registered single-cycle pulse on each accepted command change.

Function
REQ-009 cmd SHALL pass through a 2-flop synchronizer (cmd_s); there is no debounce, and every post-sync change is accepted.
REQ-010 Change detect: when cmd_s != cmd_q, cmd_q SHALL load cmd_s and cmd_evt SHALL pulse high in the same cycle that cmd_q updates.
REQ-011 Latency: a cmd change at input edge N gives cmd_evt=1 at edge N+3 and the new led_out pattern at edge N+4.
REQ-012 Prescaler: a 16-bit counter runs 0..TICK_DIV-1 and wraps to 0; tick=1 for one cycle when the count is TICK_DIV-1; free-running, cleared only by reset.
REQ-013 Step counter: 12 bits, counts ticks; a step fires on the tick where the count equals (STEP_TICKS<<cmd_q[1:0])-1, and the counter then wraps to 0.
REQ-014 Mode 00 OFF: led_out=4'h0 and active=0; the counters keep running with no visible effect.
REQ-015 Mode 01 BLINK: led_out SHALL start at 4'hF after a change event and invert on every step.
REQ-016 Mode 10 CHASE: led_out SHALL start at 4'b0001 and rotate left on every step, 4'b1000 -> 4'b0001.
REQ-017 Mode 11 PWM: a 2-bit pwm_cnt SHALL increment on every tick; led_out=4'hF when pwm_cnt <= cmd_q[1:0], else 4'h0 (duty (d+1)/4; d=3 is steady on).
REQ-018 PWM mode SHALL ignore the step counter.
REQ-019 On a change event, the step counter, pwm_cnt and the pattern register SHALL reset to the new mode's start values in the cycle after cmd_q updates; the prescaler is not cleared.
REQ-020 If a change event and a tick or step coincide, the change SHALL win: the coincident tick or step is discarded for the step counter, pwm_cnt and the pattern.
REQ-021 A change that alters only cmd[1:0] SHALL still be a full change event and restart the pattern.
REQ-022 active SHALL update in the same cycle as led_out.

Reset
REQ-023 While reset_n=0, all of the following SHALL be 0 asynchronously: sync flops, cmd_q, prescaler, step counter, pwm_cnt, pattern, led_out, active, cmd_evt.
REQ-024 After reset is released with cmd=4'h0, no cmd_evt SHALL occur because cmd_q already matches.
REQ-025 Reset assertion mid-pattern SHALL force led_out=4'h0 without waiting for a clk edge.

Verification (bench parameters TICK_DIV=4, STEP_TICKS=2)
REQ-026 Reset with cmd=4'h0 held for 100 clk -> led_out=0, active=0, cmd_evt never pulses.
REQ-027 cmd 4'h0 -> 4'b1000 at edge N -> cmd_evt at N+3; led_out=4'b0001 and active=1 at N+4; then 0010, 0100, 1000, 0001, advancing every 8 clk.
REQ-028 cmd=4'b0110 (BLINK, rate 2) -> led_out=4'hF, then toggles every 32 clk (8 ticks).
REQ-029 cmd=4'b1101 (PWM, d=1) -> led_out=4'hF for 8 clk, then 4'h0 for 8 clk, repeating.
REQ-030 In CHASE at pattern 0100, change cmd to 4'b1001 on the same cycle as a step -> no advance to 1000; led_out=0001 at N+4; the next step follows 16 clk later.
REQ-031 Pulse reset_n low mid-BLINK -> led_out=0 immediately; after release with cmd unchanged and non-zero, one cmd_evt pulse and BLINK restarts at 4'hF.
